// File: rtl/common_types_pkg.sv
// Shared types and helpers for the flash/RAM UART dump engine.
//   dump_state_t    : dump engine FSM state encoding
//   ASCII_CR/LF     : line terminator characters for hex-mode output
//   nibble_to_ascii : 4-bit value to uppercase ASCII hex digit
package common_types_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    SEND   = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4
  } dump_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/flash_uart_dump_char_sel.sv
// dump_char_sel: combinational character selector for the dump engine.
//   word      : captured memory word
//   char_idx  : index of the character within the word's output sequence
//   hex_mode  : 1 = ASCII hex digits (MS nibble first) then CR LF,
//               0 = raw bytes
//   msb_first : raw mode only; 1 = top byte first, 0 = byte 0 first
//   uart_data : selected character (0 for an out-of-range index)
module dump_char_sel
  import common_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic [DATA_W-1:0] word,
  input  logic [IDX_W-1:0]  char_idx,
  input  logic              hex_mode,
  input  logic              msb_first,
  output logic [7:0]        uart_data
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned NNIB   = DATA_W / 4;

  logic [7:0] hex_chars [NNIB + 2];
  logic [7:0] raw_chars [NBYTES];

  for (genvar k = 0; k < NNIB; k++) begin : g_hex
    assign hex_chars[k] = nibble_to_ascii(word[DATA_W-1-4*k -: 4]);
  end
  assign hex_chars[NNIB]     = ASCII_CR;
  assign hex_chars[NNIB + 1] = ASCII_LF;

  for (genvar k = 0; k < NBYTES; k++) begin : g_raw
    assign raw_chars[k] = msb_first ? word[DATA_W-1-8*k -: 8] : word[8*k +: 8];
  end

  // Compare-and-select instead of direct indexing so the index width never
  // has to match the table depth.
  always_comb begin
    uart_data = '0;
    if (hex_mode) begin
      for (int unsigned k = 0; k < NNIB + 2; k++) begin
        if (IDX_W'(k) == char_idx) uart_data = hex_chars[k];
      end
    end else begin
      for (int unsigned k = 0; k < NBYTES; k++) begin
        if (IDX_W'(k) == char_idx) uart_data = raw_chars[k];
      end
    end
  end

endmodule

// File: rtl/flash_uart_dump.sv
// flash_uart_dump: reads word_count consecutive words starting at base_addr
// through the controller request port and streams them out over a UART
// transmitter, either as raw bytes or as ASCII hex lines (CR LF per word).
// The mem_* ports map one-to-one onto axi_controller_if read/addr/ready/
// load/done.
//   clk, nrst          : clock, asynchronous active-low reset
//   start, abort       : one-cycle dump request / early stop request
//   base_addr          : first word address (sampled on accepted start)
//   word_count         : number of words (sampled on accepted start)
//   mem_read/mem_addr  : read request and address, held until mem_ready
//   mem_ready/mem_load : read data valid / read data
//   mem_done           : acknowledge, asserted in the mem_ready cycle
//   uart_start/data    : character request / character
//   uart_done          : character complete pulse
//   busy               : dump in progress
//   done/aborted       : completion pulses (normal / abort)
//   words_sent         : words fully emitted in the current or last dump
module flash_uart_dump
  import common_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int COUNT_W     = 16,
  parameter int ADDR_STRIDE = 4,
  parameter int HEX_MODE    = 0,
  parameter int MSB_FIRST   = 0
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               mem_read,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  mem_load,
  output logic               mem_done,
  output logic               uart_start,
  output logic [7:0]         uart_data,
  input  logic               uart_done,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [COUNT_W-1:0] words_sent
);

  localparam int NCHARS   = (HEX_MODE != 0) ? (DATA_W / 4 + 2) : (DATA_W / 8);
  localparam int IDX_W    = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHARS - 1);

  dump_state_t        state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COUNT_W-1:0] remain_q, remain_d;
  logic [COUNT_W-1:0] sent_q, sent_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               abort_q, abort_d;
  logic               abort_hit;
  logic [7:0]         sel_data;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      sent_q   <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      sent_q   <= sent_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    sent_d     = sent_q;
    idx_d      = idx_q;
    word_d     = word_q;
    abort_d    = abort_q;
    mem_read   = 1'b0;
    mem_done   = 1'b0;
    uart_start = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    // An abort pulse counts immediately in the cycle it arrives, as well as
    // through the latch in later cycles.
    abort_hit  = abort_q | abort;

    if (state_q != IDLE && abort) abort_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = word_count;
          sent_d   = '0;
          abort_d  = 1'b0;
          state_d  = (word_count == '0) ? FINISH : READ;
        end
      end
      READ: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          mem_done = 1'b1;
          word_d   = mem_load;
          idx_d    = '0;
          state_d  = abort_hit ? FINISH : SEND;
        end
      end
      SEND: begin
        uart_start = ~uart_done;
        if (uart_done) begin
          // A fully emitted word still goes through NEXT so it is counted;
          // NEXT then honours the abort.
          if (idx_q == LAST_IDX) begin
            state_d = NEXT;
          end else if (abort_hit) begin
            state_d = FINISH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      NEXT: begin
        sent_d   = sent_q + COUNT_W'(1);
        addr_d   = addr_q + ADDR_W'(ADDR_STRIDE);
        remain_d = remain_q - COUNT_W'(1);
        state_d  = (remain_q == COUNT_W'(1) || abort_hit) ? FINISH : READ;
      end
      FINISH: begin
        if (abort_q) aborted = 1'b1;
        else         done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  dump_char_sel #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_char_sel (
    .word      (word_q),
    .char_idx  (idx_q),
    .hex_mode  (1'(HEX_MODE != 0)),
    .msb_first (1'(MSB_FIRST != 0)),
    .uart_data (sel_data)
  );

  assign uart_data  = (state_q == SEND) ? sel_data : '0;
  assign mem_addr   = addr_q;
  assign busy       = (state_q != IDLE);
  assign words_sent = sent_q;

endmodule

// File: tb/tb_flash_uart_dump.sv
// Self-checking bench for flash_uart_dump. Three instances: raw LSB-first,
// hex, raw MSB-first. Each has its own memory and UART responder; every
// dump is compared against stream expectations built from the word values.
module tb_flash_uart_dump;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic        start_s [NI];
  logic        abort_s [NI];
  logic [31:0] base_s;
  logic [15:0] count_s;
  logic        mem_read_s [NI];
  logic        mem_ready_s [NI];
  logic        mem_done_s [NI];
  logic [31:0] mem_addr_s [NI];
  logic [31:0] mem_load_s [NI];
  logic        uart_start_s [NI];
  logic        uart_done_s [NI];
  logic [7:0]  uart_data_s [NI];
  logic        busy_s [NI];
  logic        done_s [NI];
  logic        aborted_s [NI];
  logic [15:0] words_sent_s [NI];

  int checks   = 0;
  int failures = 0;
  int mem_lat  = -1;

  logic [31:0] rd_log [NI][256];
  int          rd_n   [NI];
  logic [7:0]  ch_log [NI][1024];
  int          ch_n   [NI];
  int          done_n [NI];
  int          ab_n   [NI];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0080_0000: return 32'hDEAD_BEEF;
      32'h0000_1000: return 32'h0123_ABCD;
      32'h0000_1004: return 32'h0000_0009;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    flash_uart_dump #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .COUNT_W     (16),
      .ADDR_STRIDE (4),
      .HEX_MODE    ((g == 1) ? 1 : 0),
      .MSB_FIRST   ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .nrst       (nrst),
      .start      (start_s[g]),
      .abort      (abort_s[g]),
      .base_addr  (base_s),
      .word_count (count_s),
      .mem_read   (mem_read_s[g]),
      .mem_addr   (mem_addr_s[g]),
      .mem_ready  (mem_ready_s[g]),
      .mem_load   (mem_load_s[g]),
      .mem_done   (mem_done_s[g]),
      .uart_start (uart_start_s[g]),
      .uart_data  (uart_data_s[g]),
      .uart_done  (uart_done_s[g]),
      .busy       (busy_s[g]),
      .done       (done_s[g]),
      .aborted    (aborted_s[g]),
      .words_sent (words_sent_s[g])
    );

    initial begin : mem_resp
      bit          act;
      int          wc;
      logic [31:0] al;
      act = 0; wc = 0; al = '0;
      mem_ready_s[g] = 1'b0;
      mem_load_s[g]  = '0;
      rd_n[g]        = 0;
      forever begin
        @(negedge clk);
        if (!nrst) begin
          mem_ready_s[g] = 1'b0;
          act = 0;
        end else if (mem_ready_s[g]) begin
          mem_ready_s[g] = 1'b0;
          act = 0;
        end else if (mem_read_s[g]) begin
          if (!act) begin
            act = 1;
            al  = mem_addr_s[g];
            wc  = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 3));
          end else begin
            check_eq("mem_addr_hold", mem_addr_s[g], al);
          end
          if (wc == 0) begin
            mem_ready_s[g] = 1'b1;
            mem_load_s[g]  = memval(al);
            rd_log[g][rd_n[g] % 256] = al;
            rd_n[g]++;
            #1 check_eq("mem_done", mem_done_s[g], 1);
          end else begin
            wc--;
          end
        end
      end
    end

    initial begin : uart_resp
      bit         act;
      int         c;
      logic [7:0] ch;
      act = 0; c = 0; ch = '0;
      uart_done_s[g] = 1'b0;
      ch_n[g]        = 0;
      forever begin
        @(negedge clk);
        if (!nrst) begin
          uart_done_s[g] = 1'b0;
          act = 0;
        end else if (uart_done_s[g]) begin
          uart_done_s[g] = 1'b0;
          act = 0;
        end else if (act) begin
          check_eq("uart_data_hold", uart_data_s[g], ch);
          check_eq("uart_start_hold", uart_start_s[g], 1);
          if (c == 0) begin
            uart_done_s[g] = 1'b1;
            ch_log[g][ch_n[g] % 1024] = ch;
            ch_n[g]++;
            #1 check_eq("uart_start_gap", uart_start_s[g], 0);
          end else begin
            c--;
          end
        end else if (uart_start_s[g]) begin
          act = 1;
          ch  = uart_data_s[g];
          c   = int'($urandom_range(0, 3));
        end
      end
    end

    initial begin : evt_mon
      done_n[g] = 0;
      ab_n[g]   = 0;
      forever begin
        @(negedge clk);
        if (done_s[g])    done_n[g]++;
        if (aborted_s[g]) ab_n[g]++;
      end
    end
  end

  task automatic check_quiet(input int i);
    check_eq("q_mem_read",   mem_read_s[i],   0);
    check_eq("q_mem_done",   mem_done_s[i],   0);
    check_eq("q_mem_addr",   mem_addr_s[i],   0);
    check_eq("q_uart_start", uart_start_s[i], 0);
    check_eq("q_uart_data",  uart_data_s[i],  0);
    check_eq("q_busy",       busy_s[i],       0);
    check_eq("q_done",       done_s[i],       0);
    check_eq("q_aborted",    aborted_s[i],    0);
    check_eq("q_words_sent", words_sent_s[i], 0);
  endtask

  // akind: 0 = no abort, 1 = abort while word apt is being read,
  //        2 = abort while character apt (dump-wide index) is in flight.
  task automatic run_dump(input int i, input logic [31:0] base, input logic [15:0] cnt,
                          input int akind, input int apt, input bit poke_start);
    string       hexdig;
    logic [31:0] a, d;
    logic [31:0] exp_rd [$];
    logic [7:0]  exp_ch [$];
    int cpw, nreads, nch, nw, rd0, ch0, dn0, ab0, cyc;
    bit ab_done;
    hexdig = "0123456789ABCDEF";
    cpw = (i == 1) ? 10 : 4;
    rd0 = rd_n[i]; ch0 = ch_n[i]; dn0 = done_n[i]; ab0 = ab_n[i];

    for (int w = 0; w < int'(cnt); w++) begin
      a = base + 32'(w) * 32'd4;
      exp_rd.push_back(a);
      d = memval(a);
      if (i == 1) begin
        for (int k = 7; k >= 0; k--) exp_ch.push_back(8'(hexdig[(d >> (4 * k)) & 32'hF]));
        exp_ch.push_back(8'h0D);
        exp_ch.push_back(8'h0A);
      end else begin
        for (int k = 0; k < 4; k++) exp_ch.push_back(d[8 * ((i == 2) ? (3 - k) : k) +: 8]);
      end
    end
    if (akind == 1) begin
      nreads = apt + 1; nch = apt * cpw; nw = apt;
    end else if (akind == 2) begin
      nreads = apt / cpw + 1; nch = apt + 1; nw = (apt + 1) / cpw;
    end else begin
      nreads = int'(cnt); nch = int'(cnt) * cpw; nw = int'(cnt);
    end

    base_s = base; count_s = cnt; start_s[i] = 1'b1;
    @(negedge clk); #2;
    start_s[i] = 1'b0;
    check_eq("busy_after_start", busy_s[i], 1);
    check_eq("first_read_latency", mem_read_s[i], cnt != 0);
    if (cnt == 0) check_eq("zero_count_done", done_s[i], 1);

    ab_done = (akind == 0);
    cyc = 0;
    while (busy_s[i] && cyc < 3000) begin
      if (!ab_done) begin
        if (akind == 1 && mem_read_s[i] && (ch_n[i] - ch0) == apt * cpw) begin
          abort_s[i] = 1'b1; ab_done = 1;
        end
        if (akind == 2 && uart_start_s[i] && (ch_n[i] - ch0) == apt) begin
          abort_s[i] = 1'b1; ab_done = 1;
        end
      end
      if (poke_start && cyc == 2) begin
        start_s[i] = 1'b1; base_s = ~base; count_s = 16'd7;
      end
      @(negedge clk); #2;
      abort_s[i] = 1'b0; start_s[i] = 1'b0;
      cyc++;
    end
    check_eq("dump_terminates", cyc < 3000, 1);

    check_eq("read_count", rd_n[i] - rd0, nreads);
    for (int k = 0; k < nreads && k < rd_n[i] - rd0; k++)
      check_eq("read_addr", rd_log[i][(rd0 + k) % 256], exp_rd[k]);
    check_eq("char_count", ch_n[i] - ch0, nch);
    for (int k = 0; k < nch && k < ch_n[i] - ch0; k++)
      check_eq("char_value", ch_log[i][(ch0 + k) % 1024], exp_ch[k]);
    check_eq("words_sent", words_sent_s[i], nw);
    check_eq("done_pulses", done_n[i] - dn0, (akind == 0) ? 1 : 0);
    check_eq("aborted_pulses", ab_n[i] - ab0, (akind == 0) ? 0 : 1);
    check_eq("idle_after", busy_s[i], 0);
  endtask

  task automatic reset_mid_send(input int i);
    int cyc;
    base_s = 32'h0000_2000; count_s = 16'd4; start_s[i] = 1'b1;
    @(negedge clk); #2;
    start_s[i] = 1'b0;
    cyc = 0;
    while (!uart_start_s[i] && cyc < 200) begin
      @(negedge clk); #2;
      cyc++;
    end
    check_eq("reach_send", uart_start_s[i], 1);
    nrst = 1'b0;
    #1;
    check_quiet(i);
    @(negedge clk); #2;
    nrst = 1'b1;
    @(negedge clk); #2;
    check_eq("idle_after_reset", busy_s[i], 0);
    check_eq("no_read_after_reset", mem_read_s[i], 0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int i, cnt, akind, apt, cpw;
    logic [31:0] base;
    for (int k = 0; k < NI; k++) begin
      start_s[k] = 1'b0;
      abort_s[k] = 1'b0;
    end
    base_s = '0; count_s = '0; nrst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    for (int k = 0; k < NI; k++) check_quiet(k);
    nrst = 1'b1;
    @(negedge clk); #2;

    run_dump(0, 32'h0080_0000, 16'd1, 0, 0, 0);
    run_dump(1, 32'h0000_1000, 16'd2, 0, 0, 0);
    run_dump(0, 32'h0000_4000, 16'd0, 0, 0, 0);
    run_dump(0, 32'h0000_5000, 16'd3, 2, 5, 0);
    run_dump(0, 32'hFFFF_FFFC, 16'd2, 0, 0, 0);
    mem_lat = 7;
    run_dump(1, 32'h0000_6000, 16'd1, 0, 0, 1);
    mem_lat = -1;
    run_dump(2, 32'h0080_0000, 16'd2, 0, 0, 0);
    run_dump(1, 32'h0000_7000, 16'd3, 1, 1, 0);
    reset_mid_send(1);
    run_dump(1, 32'h0000_1000, 16'd1, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      i   = int'($urandom_range(0, NI - 1));
      cpw = (i == 1) ? 10 : 4;
      cnt = int'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
      else                           base = $urandom & 32'hFFFF_FFFC;
      akind = (cnt == 0) ? 0 : int'($urandom_range(0, 2));
      apt   = 0;
      if (akind == 1) apt = int'($urandom_range(0, cnt - 1));
      if (akind == 2) apt = int'($urandom_range(0, cnt * cpw - 2));
      run_dump(i, base, 16'(cnt), akind, apt, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
